// File: rtl/pipelined_adder_nb.sv
// pipelined_adder_nb
//   Pipelined N-bit adder/subtractor. The operands are split into SEG-bit
//   segments and one segment is resolved per stage, with the carry
//   registered between stages. Each stage register carries the whole
//   transaction: the operands, the partially built sum and the carry into
//   the next segment. A valid/ready handshake gives per-stage backpressure,
//   and an empty stage always accepts, so bubbles collapse.
//
//   Latency is L = N/SEG cycles. in_ready is combinational from out_ready.
//
// Ports
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   operands valid
//   in_ready   out  block accepts operands this cycle
//   a, b       in   N-bit operands
//   cin        in   carry-in (add) / borrow-in (sub)
//   sub        in   0: a+b+cin, 1: a-b-cin
//   out_valid  out  result valid
//   out_ready  in   downstream accepts the result
//   sum        out  N-bit result
//   cout       out  raw carry out of bit N-1 (sub: 1 = no borrow)
//   ovf        out  signed overflow (carry into MSB ^ carry out)
//
// Build option
//   PIPE_ADD_SAT_EN : when defined, the last stage clamps sum to the
//                     signed max/min on overflow; cout and ovf stay raw.

module pipelined_adder_nb #(
    parameter int N   = 32,
    parameter int SEG = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         ovf
);

    localparam int L = N / SEG;

    if ((N % SEG) != 0) begin : g_param_check
        $fatal(1, "pipelined_adder_nb: N (%0d) must be a multiple of SEG (%0d)", N, SEG);
    end

    // Stage registers
    logic [N-1:0] a_r [L];
    logic [N-1:0] b_r [L];
    logic [N-1:0] s_r [L];
    logic [L-1:0] c_r;
    logic [L-1:0] v_r;
    logic         ovf_r;

    // Per-stage sources and next values
    logic [N-1:0] a_nx [L];
    logic [N-1:0] b_nx [L];
    logic [N-1:0] s_nx [L];
    logic [L-1:0] c_src;
    logic [L-1:0] c_nx;
    logic [L-1:0] vin;
    logic [L-1:0] rdy;
    logic         ovf_nx;

    logic [SEG-1:0] p_t;
    logic [SEG-1:0] g_t;
    logic [SEG:0]   cc_t;
    logic           rdy_chain;

    // Stage k may load when it is empty or its successor can take its
    // contents; unrolled from the output backwards.
    always_comb begin
        rdy       = '0;
        rdy_chain = out_ready;
        for (int k = L - 1; k >= 0; k--) begin
            rdy_chain = !v_r[k] || rdy_chain;
            rdy[k]    = rdy_chain;
        end
    end

    always_comb begin
        ovf_nx = 1'b0;
        p_t    = '0;
        g_t    = '0;
        cc_t   = '0;
        c_nx   = '0;

        // Stage 0 takes the prepared operands; later stages take the
        // transaction held by their predecessor.
        a_nx[0]  = a;
        b_nx[0]  = sub ? ~b : b;
        s_nx[0]  = '0;
        c_src[0] = sub ? ~cin : cin;
        vin[0]   = in_valid;
        for (int k = 1; k < L; k++) begin
            a_nx[k]  = a_r[k-1];
            b_nx[k]  = b_r[k-1];
            s_nx[k]  = s_r[k-1];
            c_src[k] = c_r[k-1];
            vin[k]   = v_r[k-1];
        end

        for (int k = 0; k < L; k++) begin
            p_t     = a_nx[k][k*SEG +: SEG] ^ b_nx[k][k*SEG +: SEG];
            g_t     = a_nx[k][k*SEG +: SEG] & b_nx[k][k*SEG +: SEG];
            cc_t[0] = c_src[k];
            for (int j = 0; j < SEG; j++) begin
                cc_t[j+1] = g_t[j] | (p_t[j] & cc_t[j]);
            end
            s_nx[k][k*SEG +: SEG] = p_t ^ cc_t[SEG-1:0];
            c_nx[k] = cc_t[SEG];
        end

        // cc_t still holds the chain of the last segment here.
        ovf_nx = cc_t[SEG-1] ^ cc_t[SEG];

`ifdef PIPE_ADD_SAT_EN
        if (ovf_nx) begin
            s_nx[L-1] = s_nx[L-1][N-1] ? {1'b0, {(N-1){1'b1}}} : {1'b1, {(N-1){1'b0}}};
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_r   <= '0;
            c_r   <= '0;
            ovf_r <= 1'b0;
            for (int k = 0; k < L; k++) begin
                a_r[k] <= '0;
                b_r[k] <= '0;
                s_r[k] <= '0;
            end
        end else begin
            for (int k = 0; k < L; k++) begin
                if (rdy[k]) begin
                    v_r[k] <= vin[k];
                    if (vin[k]) begin
                        a_r[k] <= a_nx[k];
                        b_r[k] <= b_nx[k];
                        s_r[k] <= s_nx[k];
                        c_r[k] <= c_nx[k];
                    end
                end
            end
            if (rdy[L-1] && vin[L-1]) begin
                ovf_r <= ovf_nx;
            end
        end
    end

    assign in_ready  = rdy[0];
    assign out_valid = v_r[L-1];
    assign sum       = s_r[L-1];
    assign cout      = c_r[L-1];
    assign ovf       = ovf_r;

endmodule

// File: tb/tb_pipelined_adder_nb.sv
// Testbench for pipelined_adder_nb (N=32, SEG=8, L=4).
// Directed vectors with hand-computed results plus a queued stream with a
// stall window. Expected values for PIPE_ADD_SAT_EN builds follow the macro.

module tb_pipelined_adder_nb;

    localparam int N   = 32;
    localparam int SEG = 8;
    localparam int L   = 4;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  a;
    logic [N-1:0]  b;
    logic          cin;
    logic          sub;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  sum;
    logic          cout;
    logic          ovf;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pipelined_adder_nb #(.N(N), .SEG(SEG)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    // Reference: {ovf, cout, sum} straight from the arithmetic definition.
    function automatic logic [33:0] model(input logic [31:0] ma, input logic [31:0] mb,
                                          input logic mcin, input logic msub);
        logic [31:0] beff;
        logic        c0;
        logic [32:0] full;
        logic [31:0] low;
        logic        o;
        logic [31:0] s;
        beff = msub ? ~mb : mb;
        c0   = msub ? ~mcin : mcin;
        full = {1'b0, ma} + {1'b0, beff} + {32'd0, c0};
        low  = {1'b0, ma[30:0]} + {1'b0, beff[30:0]} + {31'd0, c0};
        o    = low[31] ^ full[32];
        s    = full[31:0];
`ifdef PIPE_ADD_SAT_EN
        if (o) s = s[31] ? 32'h7FFF_FFFF : 32'h8000_0000;
`endif
        return {o, full[32], s};
    endfunction

    // Drives one operation with out_ready=1 and collects the result; called
    // one cycle-phase after a rising edge, returns at the same phase.
    // olat = number of edges from the accepting edge until out_valid is
    // sampled high, or -1 on timeout.
    task automatic run_one(input logic [31:0] ia, input logic [31:0] ib,
                           input logic icin, input logic isub,
                           output logic [31:0] osum, output logic ocout,
                           output logic oovf, output int olat);
        out_ready = 1'b1;
        a = ia; b = ib; cin = icin; sub = isub;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        olat = 1;
        while (!out_valid && olat < 20) begin
            @(posedge clk); #1;
            olat++;
        end
        if (!out_valid) olat = -1;
        osum  = sum;
        ocout = cout;
        oovf  = ovf;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_checks++; if (sum !== 32'h0) begin n_fail++; $display("FAIL reset_sum: got %h expected 00000000", sum); end
        n_checks++; if (cout !== 1'b0) begin n_fail++; $display("FAIL reset_cout: got %b expected 0", cout); end
        n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_add;
        logic [31:0] s; logic c, o; int lat;
        run_one(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, s, c, o, lat);
        n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL add_latency: got %0d expected 4", lat); end
        n_checks++; if (s !== 32'h0000_0100) begin n_fail++; $display("FAIL add_sum: got %h expected 00000100", s); end
        n_checks++; if (c !== 1'b0) begin n_fail++; $display("FAIL add_cout: got %b expected 0", c); end
        n_checks++; if (o !== 1'b0) begin n_fail++; $display("FAIL add_ovf: got %b expected 0", o); end
    endtask

    task automatic test_carry_ripple;
        logic [31:0] s; logic c, o; int lat;
        logic [31:0] exp_s;
        run_one(32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, s, c, o, lat);
        n_checks++; if (s !== 32'h0) begin n_fail++; $display("FAIL ripple_sum: got %h expected 00000000", s); end
        n_checks++; if (c !== 1'b1) begin n_fail++; $display("FAIL ripple_cout: got %b expected 1", c); end
        n_checks++; if (o !== 1'b0) begin n_fail++; $display("FAIL ripple_ovf: got %b expected 0", o); end
        run_one(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, s, c, o, lat);
`ifdef PIPE_ADD_SAT_EN
        exp_s = 32'h7FFF_FFFF;
`else
        exp_s = 32'h8000_0000;
`endif
        n_checks++; if (s !== exp_s) begin n_fail++; $display("FAIL posovf_sum: got %h expected %h", s, exp_s); end
        n_checks++; if (c !== 1'b0) begin n_fail++; $display("FAIL posovf_cout: got %b expected 0", c); end
        n_checks++; if (o !== 1'b1) begin n_fail++; $display("FAIL posovf_ovf: got %b expected 1", o); end
    endtask

    task automatic test_sub;
        logic [31:0] s; logic c, o; int lat;
        logic [31:0] exp_s;
        run_one(32'd5, 32'd7, 1'b0, 1'b1, s, c, o, lat);
        n_checks++; if (s !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL sub_sum: got %h expected fffffffe", s); end
        n_checks++; if (c !== 1'b0) begin n_fail++; $display("FAIL sub_cout: got %b expected 0", c); end
        n_checks++; if (o !== 1'b0) begin n_fail++; $display("FAIL sub_ovf: got %b expected 0", o); end
        run_one(32'h8000_0000, 32'h1, 1'b0, 1'b1, s, c, o, lat);
`ifdef PIPE_ADD_SAT_EN
        exp_s = 32'h8000_0000;
`else
        exp_s = 32'h7FFF_FFFF;
`endif
        n_checks++; if (s !== exp_s) begin n_fail++; $display("FAIL negovf_sum: got %h expected %h", s, exp_s); end
        n_checks++; if (c !== 1'b1) begin n_fail++; $display("FAIL negovf_cout: got %b expected 1", c); end
        n_checks++; if (o !== 1'b1) begin n_fail++; $display("FAIL negovf_ovf: got %b expected 1", o); end
        run_one(32'd10, 32'd3, 1'b1, 1'b1, s, c, o, lat);
        n_checks++; if (s !== 32'd6) begin n_fail++; $display("FAIL sub_borrow_sum: got %h expected 00000006", s); end
        n_checks++; if (c !== 1'b1) begin n_fail++; $display("FAIL sub_borrow_cout: got %b expected 1", c); end
        n_checks++; if (o !== 1'b0) begin n_fail++; $display("FAIL sub_borrow_ovf: got %b expected 0", o); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] va [20];
        logic [31:0] vb [20];
        logic        vc [20];
        logic        vs [20];
        logic [33:0] exp_q [$];
        logic [33:0] e;
        logic [33:0] held;
        logic        stalled_prev, saw_full, exp_rdy, acc, emit;
        int sent, recv, cyc;
        sent = 0; recv = 0; cyc = 0;
        stalled_prev = 1'b0; saw_full = 1'b0; held = '0;
        for (int i = 0; i < 20; i++) begin
            va[i] = $urandom;
            vb[i] = $urandom;
            vc[i] = 1'($urandom_range(0, 1));
            vs[i] = 1'($urandom_range(0, 1));
        end
        va[3] = 32'h7FFF_FFFF; vb[3] = 32'h0000_0001; vs[3] = 1'b0; vc[3] = 1'b0;
        while ((sent < 20 || recv < 20) && cyc < 200) begin
            out_ready = !(cyc >= 6 && cyc <= 10);
            in_valid  = (sent < 20);
            if (sent < 20) begin
                a = va[sent]; b = vb[sent]; cin = vc[sent]; sub = vs[sent];
            end
            #1;
            if (sent < 20) begin
                exp_rdy = out_ready || ((sent - recv) < L);
                n_checks++;
                if (in_ready !== exp_rdy) begin
                    n_fail++;
                    $display("FAIL stream_in_ready cyc %0d: got %b expected %b", cyc, in_ready, exp_rdy);
                end
                if (!in_ready) saw_full = 1'b1;
            end
            if (out_valid && !out_ready) begin
                if (stalled_prev) begin
                    n_checks++;
                    if ({ovf, cout, sum} !== held) begin
                        n_fail++;
                        $display("FAIL stall_hold cyc %0d: got %h expected %h", cyc, {ovf, cout, sum}, held);
                    end
                end
                held = {ovf, cout, sum};
                stalled_prev = 1'b1;
            end else begin
                stalled_prev = 1'b0;
            end
            acc  = in_valid && in_ready;
            emit = out_valid && out_ready;
            if (emit) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL stream_extra cyc %0d: got %h expected no output", cyc, {ovf, cout, sum});
                end else begin
                    e = exp_q.pop_front();
                    if ({ovf, cout, sum} !== e) begin
                        n_fail++;
                        $display("FAIL stream_result %0d: got %h expected %h", recv, {ovf, cout, sum}, e);
                    end
                end
                recv++;
            end
            if (acc) begin
                exp_q.push_back(model(a, b, cin, sub));
                sent++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n_checks++; if (sent !== 20 || recv !== 20) begin n_fail++; $display("FAIL stream_count: got sent %0d recv %0d expected 20 20", sent, recv); end
        n_checks++; if (saw_full !== 1'b1) begin n_fail++; $display("FAIL stream_full: got in_ready never low expected a drop"); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_drain: got out_valid %b expected 0", out_valid); end
    endtask

    task automatic test_bubble_collapse;
        out_ready = 1'b0;
        a = 32'd1; b = 32'd2; cin = 1'b0; sub = 1'b0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        a = 32'h1234_5678; b = 32'h1111_1111;
        in_valid = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bubble_accept: got in_ready %b expected 1", in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (out_valid !== 1'b1 || sum !== 32'd3) begin n_fail++; $display("FAIL bubble_op0_held: got valid %b sum %h expected 1 00000003", out_valid, sum); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bubble_two_free: got in_ready %b expected 1", in_ready); end
        out_ready = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (out_valid !== 1'b1 || sum !== 32'h2345_6789) begin n_fail++; $display("FAIL bubble_op1_next: got valid %b sum %h expected 1 23456789", out_valid, sum); end
        @(posedge clk); #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bubble_drain: got out_valid %b expected 0", out_valid); end
    endtask

    task automatic test_reset_midflight;
        logic [31:0] s; logic c, o; int lat, stale;
        out_ready = 1'b1;
        cin = 1'b0; sub = 1'b0;
        in_valid = 1'b1;
        a = 32'h100; b = 32'h23;
        @(posedge clk); #1;
        a = 32'h200; b = 32'h5;
        @(posedge clk); #1;
        a = 32'h10;  b = 32'h10;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (out_valid !== 1'b1 || sum !== 32'h123) begin n_fail++; $display("FAIL rst_pre_valid: got valid %b sum %h expected 1 00000123", out_valid, sum); end
        #1;
        rst_n = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_async_valid: got %b expected 0", out_valid); end
        n_checks++; if (sum !== 32'h0) begin n_fail++; $display("FAIL rst_async_sum: got %h expected 00000000", sum); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_async_in_ready: got %b expected 1", in_ready); end
        #4;
        rst_n = 1'b1;
        stale = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (out_valid) stale++;
        end
        n_checks++; if (stale !== 0) begin n_fail++; $display("FAIL rst_stale: got %0d stale outputs expected 0", stale); end
        run_one(32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, s, c, o, lat);
        n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL rst_next_latency: got %0d expected 4", lat); end
        n_checks++; if (s !== 32'd2) begin n_fail++; $display("FAIL rst_next_sum: got %h expected 00000002", s); end
    endtask

    initial begin
        in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        test_reset();
        test_add();
        test_carry_ripple();
        test_sub();
        test_back_to_back();
        test_bubble_collapse();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test expected completion before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
